// File: rtl/ks_add_arbiter_if.sv
// Requester/adder bus of ks_add_arbiter: operand handshake, adder operand/sum lines
// and the shared response. slave = arbiter side, master = requesters plus adder.
interface ks_add_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned W       = 16
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*W-1:0] req_a;
  logic [NUM_REQ*W-1:0] req_b;
  logic [W-1:0]         add_x;
  logic [W-1:0]         add_y;
  logic [W:0]           add_s;
  logic [NUM_REQ-1:0]   rsp_valid;
  logic [W:0]           rsp_sum;

  modport slave (
    input  req_valid, req_a, req_b, add_s,
    output req_ready, add_x, add_y, rsp_valid, rsp_sum
  );

  modport master (
    output req_valid, req_a, req_b, add_s,
    input  req_ready, add_x, add_y, rsp_valid, rsp_sum
  );
endinterface

// File: rtl/ks_add_arbiter.sv
// Round-robin arbiter sharing one registered adder among NUM_REQ requesters, with a
// tag pipeline routing each sum back. KS_ADD_ARB_CNT_EN adds a saturating op_count.
module ks_add_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned W       = 16,
  parameter int unsigned ADD_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  ks_add_arbiter_if.slave bus,
  output logic            busy
`ifdef KS_ADD_ARB_CNT_EN
  ,
  output logic [15:0]     op_count
`endif
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned DEPTH = ADD_LAT + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [DEPTH-1:0]   tag_v_q, tag_v_d;
  logic [IDX_W-1:0]   tag_g_q [DEPTH];
  logic [IDX_W-1:0]   tag_g_d [DEPTH];
  logic [W-1:0]       add_x_q, add_x_d;
  logic [W-1:0]       add_y_q, add_y_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [W:0]         rsp_sum_q, rsp_sum_d;
  logic               busy_q, busy_d;

  logic [W-1:0]       op_a [NUM_REQ];
  logic [W-1:0]       op_b [NUM_REQ];
  logic               grant_vld;
  logic [IDX_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] ready_c;
  logic               issue_allow;
  logic               accept;
  logic               in_flight;
  int unsigned        cand;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      op_a[i] = bus.req_a[i*W +: W];
      op_b[i] = bus.req_b[i*W +: W];
    end
  end

  // Search upward from rr_ptr with wrap; first valid requester wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(rr_ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!grant_vld && bus.req_valid[cand[IDX_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    issue_allow = (state_q == ST_RUN) && en;
    ready_c     = '0;
    if (issue_allow && grant_vld) ready_c[grant_idx] = 1'b1;
    accept = |(ready_c & bus.req_valid);
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      if (grant_idx == IDX_W'(NUM_REQ - 1)) rr_ptr_d = '0;
      else                                   rr_ptr_d = grant_idx + 1'b1;
    end
  end

  always_comb begin
    in_flight = |tag_v_q;
    state_d   = state_q;
    case (state_q)
      ST_IDLE:  if (en) state_d = ST_RUN;
      ST_RUN:   if (!en) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (en)              state_d = ST_RUN;
        else if (!in_flight) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    add_x_d = add_x_q;
    add_y_d = add_y_q;
    if (accept) begin
      add_x_d = op_a[grant_idx];
      add_y_d = op_b[grant_idx];
    end

    // Stage 0 is written on the issue edge; the last stage lines up with add_s.
    tag_v_d[0] = accept;
    tag_g_d[0] = grant_idx;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      tag_v_d[i] = tag_v_q[i-1];
      tag_g_d[i] = tag_g_q[i-1];
    end

    rsp_valid_d = '0;
    rsp_sum_d   = rsp_sum_q;
    if (tag_v_q[DEPTH-1]) begin
      rsp_valid_d[tag_g_q[DEPTH-1]] = 1'b1;
      rsp_sum_d                     = bus.add_s;
    end

    busy_d = (state_d != ST_IDLE) || (|tag_v_d);
  end

`ifdef KS_ADD_ARB_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if ((|rsp_valid_d) && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign op_count = cnt_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      tag_v_q     <= '0;
      tag_g_q     <= '{default: '0};
      add_x_q     <= '0;
      add_y_q     <= '0;
      rsp_valid_q <= '0;
      rsp_sum_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      tag_v_q     <= tag_v_d;
      tag_g_q     <= tag_g_d;
      add_x_q     <= add_x_d;
      add_y_q     <= add_y_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.req_ready = ready_c;
  assign bus.add_x     = add_x_q;
  assign bus.add_y     = add_y_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_ks_add_arbiter.sv
// Bench for ks_add_arbiter: transaction-level model plus directed vectors with literal
// expectations; define KS_ADD_ARB_CNT_EN to also exercise op_count.
module tb_ks_add_arbiter;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned W       = 16;
  localparam int unsigned ADD_LAT = 1;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic busy;
`ifdef KS_ADD_ARB_CNT_EN
  logic [15:0] op_count;
`endif

  ks_add_arbiter_if #(.NUM_REQ(NUM_REQ), .W(W)) bus_if ();

  ks_add_arbiter #(.NUM_REQ(NUM_REQ), .W(W), .ADD_LAT(ADD_LAT)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .bus  (bus_if),
    .busy (busy)
`ifdef KS_ADD_ARB_CNT_EN
    ,
    .op_count (op_count)
`endif
  );

  always #5 clk = ~clk;

  // External registered adder with ADD_LAT clocks of latency.
  logic [W:0] s_pipe [ADD_LAT+1];
  always @(posedge clk) begin
    s_pipe[0] <= {1'b0, bus_if.add_x} + {1'b0, bus_if.add_y};
    for (int i = 1; i <= ADD_LAT; i++) s_pipe[i] <= s_pipe[i-1];
  end
  generate
    if (ADD_LAT == 0) begin : g_comb_add
      assign bus_if.add_s = {1'b0, bus_if.add_x} + {1'b0, bus_if.add_y};
    end else begin : g_reg_add
      assign bus_if.add_s = s_pipe[ADD_LAT-1];
    end
  endgenerate

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0=idle 1=run 2=drain; scoreboard of (response cycle, requester, sum).
  typedef struct {
    int         due;
    int         idx;
    logic [W:0] sum;
  } ent_t;

  ent_t               sb[$];
  int                 m_mode = 0;
  int                 m_ptr  = 0;
  int                 cyc    = 0;
  bit                 chk_en = 1'b0;
  logic [W-1:0]       e_add_x, e_add_y;
  logic [NUM_REQ-1:0] e_rsp_valid;
  logic [W:0]         e_rsp_sum;
  logic               e_busy;
  logic [15:0]        e_count;

  function automatic int exp_grant();
    int j;
    if (m_mode != 1 || en !== 1'b1) return -1;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      j = (m_ptr + k) % int'(NUM_REQ);
      if (bus_if.req_valid[j] === 1'b1) return j;
    end
    return -1;
  endfunction

  initial begin
    int g;
    bit pend;
    forever begin
      @(posedge clk);
      if (rst === 1'b1) begin
        sb.delete();
        m_mode = 0; m_ptr = 0;
        e_add_x = '0; e_add_y = '0; e_rsp_valid = '0; e_rsp_sum = '0;
        e_busy = 1'b0; e_count = '0;
        chk_en = 1'b1;
        cyc++;
      end else begin
        g = exp_grant();
        pend = 1'b0;
        foreach (sb[i]) if (sb[i].due > cyc) pend = 1'b1;
        cyc++;
        e_rsp_valid = '0;
        for (int i = 0; i < sb.size(); i++) begin
          if (sb[i].due == cyc) begin
            e_rsp_valid[sb[i].idx] = 1'b1;
            e_rsp_sum = sb[i].sum;
            if (e_count != 16'hFFFF) e_count = e_count + 16'd1;
            sb.delete(i);
            break;
          end
        end
        if (g >= 0) begin
          e_add_x = bus_if.req_a[g*W +: W];
          e_add_y = bus_if.req_b[g*W +: W];
          sb.push_back('{due: cyc + int'(ADD_LAT) + 1, idx: g,
                         sum: {1'b0, e_add_x} + {1'b0, e_add_y}});
          m_ptr = (g + 1) % int'(NUM_REQ);
        end
        if (en === 1'b1)  m_mode = 1;
        else if (m_mode == 1) m_mode = 2;
        else if (m_mode == 2) m_mode = pend ? 2 : 0;
        e_busy = (m_mode != 0);
        foreach (sb[i]) if (sb[i].due > cyc) e_busy = 1'b1;
      end
    end
  end

  initial begin
    int g;
    logic [NUM_REQ-1:0] e_ready;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        g = exp_grant();
        e_ready = '0;
        if (g >= 0) e_ready[g] = 1'b1;
        chk("m_req_ready", bus_if.req_ready, e_ready);
        chk("m_add_x", bus_if.add_x, e_add_x);
        chk("m_add_y", bus_if.add_y, e_add_y);
        chk("m_rsp_valid", bus_if.rsp_valid, e_rsp_valid);
        chk("m_rsp_sum", bus_if.rsp_sum, e_rsp_sum);
        chk("m_busy", busy, e_busy);
`ifdef KS_ADD_ARB_CNT_EN
        chk("m_op_count", op_count, e_count);
`endif
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    bus_if.req_a[i*W +: W] = a;
    bus_if.req_b[i*W +: W] = b;
  endtask

  int exp_order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int hits [NUM_REQ];
  int rsp_cycles;
  int gidx;

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    bus_if.req_valid = '0;
    bus_if.req_a     = '0;
    bus_if.req_b     = '0;
    tick(2);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", bus_if.req_ready, 32'h0);
    chk("rst_add_x", bus_if.add_x, 32'h0);
    chk("rst_rsp_valid", bus_if.rsp_valid, 32'h0);
    chk("rst_rsp_sum", bus_if.rsp_sum, 32'h0);
    chk("rst_busy", busy, 32'h0);

    // Single request from requester 1.
    en = 1'b1;
    tick(1);
    set_op(1, 16'h1234, 16'h0FF0);
    bus_if.req_valid = 4'b0010;
    @(negedge clk);
    chk("single_ready", bus_if.req_ready, 32'h2);
    tick(1);
    bus_if.req_valid = '0;
    @(negedge clk);
    chk("single_add_x", bus_if.add_x, 32'h1234);
    chk("single_add_y", bus_if.add_y, 32'h0FF0);
    tick(2);
    @(negedge clk);
    chk("single_rsp_valid", bus_if.rsp_valid, 32'h2);
    chk("single_rsp_sum", bus_if.rsp_sum, 32'h02224);

    // Carry out of the top bit.
    tick(1);
    set_op(3, 16'hFFFF, 16'h0001);
    bus_if.req_valid = 4'b1000;
    @(negedge clk);
    chk("carry_ready", bus_if.req_ready, 32'h8);
    tick(1);
    bus_if.req_valid = '0;
    tick(2);
    @(negedge clk);
    chk("carry_rsp_valid", bus_if.rsp_valid, 32'h8);
    chk("carry_rsp_sum", bus_if.rsp_sum, 32'h10000);

    // Fairness: all four held valid for 8 cycles.
    tick(1);
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      set_op(i, 16'h1111 * 16'(i + 1), 16'h0101 * 16'(i + 3));
      hits[i] = 0;
    end
    rsp_cycles = 0;
    bus_if.req_valid = 4'b1111;
    for (int c = 0; c < 11; c++) begin
      if (c == 8) bus_if.req_valid = '0;
      @(negedge clk);
      if (c < 8) begin
        gidx = -1;
        for (int r = 0; r < int'(NUM_REQ); r++) if (bus_if.req_ready[r] === 1'b1) gidx = r;
        chk($sformatf("fair_grant%0d", c), gidx, exp_order[c]);
      end
      if (c >= 3) begin
        if (bus_if.rsp_valid != '0) rsp_cycles++;
        for (int r = 0; r < int'(NUM_REQ); r++) if (bus_if.rsp_valid[r] === 1'b1) hits[r]++;
      end
      tick(1);
    end
    for (int r = 0; r < int'(NUM_REQ); r++) chk($sformatf("fair_hits%0d", r), hits[r], 2);
    chk("fair_no_gaps", rsp_cycles, 8);

    // Drain with two operations in flight.
    set_op(0, 16'h0100, 16'h0001);
    set_op(2, 16'h2000, 16'h0022);
    bus_if.req_valid = 4'b0101;
    @(negedge clk);
    chk("drain_ready0", bus_if.req_ready, 32'h1);
    tick(1);
    @(negedge clk);
    chk("drain_ready1", bus_if.req_ready, 32'h4);
    tick(1);
    en = 1'b0;
    @(negedge clk);
    chk("drain_gate", bus_if.req_ready, 32'h0);
    tick(1);
    @(negedge clk);
    chk("drain_rsp0", bus_if.rsp_valid, 32'h1);
    chk("drain_sum0", bus_if.rsp_sum, 32'h0101);
    chk("drain_ready_off", bus_if.req_ready, 32'h0);
    tick(1);
    @(negedge clk);
    chk("drain_rsp1", bus_if.rsp_valid, 32'h4);
    chk("drain_sum1", bus_if.rsp_sum, 32'h2022);
    chk("drain_busy_last", busy, 32'h1);
    tick(1);
    bus_if.req_valid = '0;
    @(negedge clk);
    chk("drain_busy_low", busy, 32'h0);

    // Reset one cycle after an accept.
    en = 1'b1;
    tick(1);
    set_op(1, 16'h4444, 16'h1111);
    bus_if.req_valid = 4'b0010;
    @(negedge clk);
    chk("rstmid_ready", bus_if.req_ready, 32'h2);
    tick(1);
    bus_if.req_valid = '0;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_rsp_valid", bus_if.rsp_valid, 32'h0);
    chk("rstmid_busy", busy, 32'h0);
    chk("rstmid_add_x", bus_if.add_x, 32'h0);
    tick(1);
    set_op(3, 16'h0003, 16'h0004);
    bus_if.req_valid = 4'b1010;
    @(negedge clk);
    chk("rstmid_no_rsp", bus_if.rsp_valid, 32'h0);
    chk("rstmid_lowest", bus_if.req_ready, 32'h2);
    tick(1);
    bus_if.req_valid = '0;
    tick(4);

`ifdef KS_ADD_ARB_CNT_EN
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    set_op(0, 16'h0010, 16'h0020);
    bus_if.req_valid = 4'b0001;
    tick(5);
    bus_if.req_valid = '0;
    tick(5);
    @(negedge clk);
    chk("cnt_five", op_count, 32'd5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    chk("cnt_clear", op_count, 32'd0);
`endif

    tick(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
